apb_pwm_hbridge: RTL

Parametrised APB3 slave generating NUM_CH independent PWM channels, each steering a two-input H-bridge driver leg pair (DRV8833-style: IN1/IN2). Successor to the fixed two-channel PWM slave behind the MSS APB master via CoreAPB3 slot 0. Adds:
- per-channel period/duty registers with period-boundary shadowing
- direction control with dead time
- brake and coast modes
- sticky wrap status flags

---
 rtl/apb_pwm_hbridge.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/apb_pwm_hbridge.sv
// APB3 slave driving NUM_CH period-shadowed PWM channels into H-bridge leg pairs,
// with dead time on direction change, brake/coast control and sticky wrap flags.
module apb_pwm_hbridge #(
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned DEAD_CYC = 4
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic                PSEL,
    input  logic                PENABLE,
    input  logic                PWRITE,
    input  logic [7:0]          PADDR,
    input  logic [31:0]         PWDATA,
    output logic [31:0]         PRDATA,
    output logic                PREADY,
    output logic                PSLVERR,
    output logic [NUM_CH-1:0]   PWM,
    output logic [2*NUM_CH-1:0] H_IN
);
    logic                gen_q, gen_d;
    logic [NUM_CH-1:0]   status_q, status_d;
    logic [NUM_CH-1:0]   cen_q, cen_d, dir_q, dir_d, brk_q, brk_d;
    logic [NUM_CH-1:0]   dir_sh_q, dir_sh_d, run_p_q, run_p_d, pwm_q, pwm_d;
    logic [2*NUM_CH-1:0] hin_q, hin_d;
    logic [CNT_W-1:0]    per_q [NUM_CH];
    logic [CNT_W-1:0]    per_d [NUM_CH];
    logic [CNT_W-1:0]    duty_q [NUM_CH];
    logic [CNT_W-1:0]    duty_d [NUM_CH];
    logic [CNT_W-1:0]    per_sh_q [NUM_CH];
    logic [CNT_W-1:0]    per_sh_d [NUM_CH];
    logic [CNT_W-1:0]    duty_sh_q [NUM_CH];
    logic [CNT_W-1:0]    duty_sh_d [NUM_CH];
    logic [CNT_W-1:0]    cnt_q [NUM_CH];
    logic [CNT_W-1:0]    cnt_d [NUM_CH];
    logic [7:0]          dc_q [NUM_CH];
    logic [7:0]          dc_d [NUM_CH];

    logic [NUM_CH-1:0]   ch_hit, run_v, first_v, wrap_v, load_v;
    logic                acc, mapped, wr, wr_stat;
    logic                unused_bits;

    assign PREADY      = 1'b1;
    assign PWM         = pwm_q;
    assign H_IN        = hin_q;
    assign unused_bits = ^{PADDR[1:0], PWDATA};

    always_comb begin
        acc    = PSEL & PENABLE;
        ch_hit = '0;
        for (int unsigned c = 0; c < NUM_CH; c++)
            ch_hit[c] = (PADDR[7:4] == 4'(c + 1)) && (PADDR[3:2] != 2'd3);
        mapped  = (PADDR[7:2] == 6'd0) || (PADDR[7:2] == 6'd1) || (|ch_hit);
        wr      = acc & PWRITE & mapped;
        wr_stat = wr & (PADDR[7:2] == 6'd1);
        PSLVERR = acc & ~mapped;
        PRDATA  = '0;
        if (PADDR[7:2] == 6'd0)
            PRDATA = {16'd0, 8'(NUM_CH), 7'd0, gen_q};
        else if (PADDR[7:2] == 6'd1)
            PRDATA = 32'(status_q);
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (ch_hit[c]) begin
                case (PADDR[3:2])
                    2'd0:    PRDATA = 32'(per_q[c]);
                    2'd1:    PRDATA = 32'(duty_q[c]);
                    2'd2:    PRDATA = {29'd0, brk_q[c], dir_q[c], cen_q[c]};
                    default: PRDATA = '0;
                endcase
            end
        end
    end

    always_comb begin
        gen_d    = gen_q;
        status_d = status_q;
        cen_d    = cen_q;
        dir_d    = dir_q;
        brk_d    = brk_q;
        dir_sh_d = dir_sh_q;
        run_p_d  = '0;
        pwm_d    = '0;
        hin_d    = '0;
        run_v    = '0;
        first_v  = '0;
        wrap_v   = '0;
        load_v   = '0;
        if (wr && PADDR[7:2] == 6'd0)
            gen_d = PWDATA[0];
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            per_d[c]     = per_q[c];
            duty_d[c]    = duty_q[c];
            per_sh_d[c]  = per_sh_q[c];
            duty_sh_d[c] = duty_sh_q[c];
            cnt_d[c]     = '0;
            dc_d[c]      = '0;
            if (wr && ch_hit[c]) begin
                case (PADDR[3:2])
                    2'd0: per_d[c] = PWDATA[CNT_W-1:0];
                    2'd1: duty_d[c] = PWDATA[CNT_W-1:0];
                    2'd2: begin
                        cen_d[c] = PWDATA[0];
                        dir_d[c] = PWDATA[1];
                        brk_d[c] = PWDATA[2];
                    end
                    default: ;
                endcase
            end
            run_v[c]   = gen_q & cen_q[c];
            first_v[c] = run_v[c] & ~run_p_q[c];
            wrap_v[c]  = run_v[c] & run_p_q[c] & (cnt_q[c] == per_sh_q[c]);
            load_v[c]  = first_v[c] | wrap_v[c];
            run_p_d[c] = run_v[c];
            if (load_v[c]) begin
                per_sh_d[c]  = per_q[c];
                duty_sh_d[c] = duty_q[c];
                dir_sh_d[c]  = dir_q[c];
            end
            if (run_v[c] && !load_v[c])
                cnt_d[c] = cnt_q[c] + CNT_W'(1);
            // Shadows are still stale on the load cycle, so the first compare is held off.
            pwm_d[c] = run_v[c] & ~first_v[c] & (cnt_q[c] < duty_sh_q[c]);
            if (run_v[c]) begin
                if (load_v[c] && (dir_q[c] != dir_sh_q[c]))
                    dc_d[c] = 8'(DEAD_CYC);
                else if (dc_q[c] != 8'd0)
                    dc_d[c] = dc_q[c] - 8'd1;
            end
            if (!run_v[c])
                hin_d[2*c +: 2] = 2'b00;
            else if (brk_q[c])
                hin_d[2*c +: 2] = 2'b11;
            else if (dc_q[c] != 8'd0)
                hin_d[2*c +: 2] = 2'b00;
            else if (!dir_sh_q[c])
                hin_d[2*c +: 2] = {1'b0, pwm_d[c]};
            else
                hin_d[2*c +: 2] = {pwm_d[c], 1'b0};
            status_d[c] = (status_q[c] & ~(wr_stat & PWDATA[c])) | wrap_v[c];
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            gen_q    <= '0;
            status_q <= '0;
            cen_q    <= '0;
            dir_q    <= '0;
            brk_q    <= '0;
            dir_sh_q <= '0;
            run_p_q  <= '0;
            pwm_q    <= '0;
            hin_q    <= '0;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                per_q[c]     <= '0;
                duty_q[c]    <= '0;
                per_sh_q[c]  <= '0;
                duty_sh_q[c] <= '0;
                cnt_q[c]     <= '0;
                dc_q[c]      <= '0;
            end
        end else begin
            gen_q    <= gen_d;
            status_q <= status_d;
            cen_q    <= cen_d;
            dir_q    <= dir_d;
            brk_q    <= brk_d;
            dir_sh_q <= dir_sh_d;
            run_p_q  <= run_p_d;
            pwm_q    <= pwm_d;
            hin_q    <= hin_d;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                per_q[c]     <= per_d[c];
                duty_q[c]    <= duty_d[c];
                per_sh_q[c]  <= per_sh_d[c];
                duty_sh_q[c] <= duty_sh_d[c];
                cnt_q[c]     <= cnt_d[c];
                dc_q[c]      <= dc_d[c];
            end
        end
    end
endmodule
